// File: rtl/down_timer.sv
// Loadable down-counter timer with optional auto-reload.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a load; load_ready high, count holds last value
// RUN   | counting down on en; tc pulses at the 1 -> terminal edge
//
// A zero load is a degenerate run: it completes immediately and pulses tc
// without ever entering RUN. The reload register only changes on an
// accepted load, so auto-reload always restarts from the last start value.
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             en,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             tc_q;
    logic             tc_d;
    logic             at_terminal;

    // Count of one (or the unreachable zero) is treated as terminal so the
    // counter can never step below zero.
    assign at_terminal = (count_q <= WIDTH'(1));

    // Next-state, next-count and terminal-count pulse decode.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    count_d  = load_value;
                    reload_d = load_value;
                    if (load_value != '0) begin
                        state_d = RUN;
                    end else begin
                        tc_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (en) begin
                    if (at_terminal) begin
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, reload and tc registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count      = count_q;
    assign busy       = (state_q == RUN);
    assign load_ready = (state_q == IDLE);
    assign tc         = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Testbench for down_timer: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_down_timer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             en = 1'b0;
    logic             stop = 1'b0;
    logic             auto_reload = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;

    int errors = 0;
    int checks = 0;

    // Behavioural model: running flag, current value, stored start, pulse.
    bit m_running = 0;
    int m_value   = 0;
    int m_start   = 0;
    bit m_pulse   = 0;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_value  (load_value),
        .load_ready  (load_ready),
        .en          (en),
        .stop        (stop),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .tc          (tc)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_running = 0;
        m_value   = 0;
        m_start   = 0;
        m_pulse   = 0;
    endtask

    // Apply one clock edge of the timer rules to the model.
    task automatic model_edge();
        m_pulse = 0;
        if (!m_running) begin
            if (load_valid) begin
                m_value = int'(load_value);
                m_start = int'(load_value);
                if (m_value == 0) m_pulse = 1;
                else              m_running = 1;
            end
        end else if (stop) begin
            m_running = 0;
        end else if (en) begin
            if (m_value == 1) begin
                m_pulse = 1;
                if (auto_reload) m_value = m_start;
                else begin
                    m_value   = 0;
                    m_running = 0;
                end
            end else begin
                m_value = m_value - 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        load_valid  = 1'b0;
        load_value  = '0;
        en          = 1'b0;
        stop        = 1'b0;
        auto_reload = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b want=0", tc); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got=%b want=1", load_ready); end
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_one_shot();
        int exp_c [6] = '{5, 4, 3, 2, 1, 0};
        bit exp_t [6] = '{0, 0, 0, 0, 0, 1};
        bit exp_b [6] = '{1, 1, 1, 1, 1, 0};
        load_valid = 1'b1; load_value = 8'd5; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            load_valid = 1'b0;
            checks++; if (count !== WIDTH'(exp_c[i])) begin errors++; $display("FAIL oneshot_count[%0d] got=%0d want=%0d", i, count, exp_c[i]); end
            checks++; if (tc !== exp_t[i]) begin errors++; $display("FAIL oneshot_tc[%0d] got=%b want=%b", i, tc, exp_t[i]); end
            checks++; if (busy !== exp_b[i]) begin errors++; $display("FAIL oneshot_busy[%0d] got=%b want=%b", i, busy, exp_b[i]); end
        end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL oneshot_ready got=%b want=1", load_ready); end
        tick();
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL oneshot_tc_after got=%b want=0", tc); end
        idle_inputs();
    endtask

    task automatic test_auto_reload();
        int exp_c [10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
        int pulses = 0;
        load_valid = 1'b1; load_value = 8'd3; en = 1'b1; auto_reload = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            load_valid = 1'b0;
            if (tc === 1'b1) pulses++;
            checks++; if (count !== WIDTH'(exp_c[i])) begin errors++; $display("FAIL reload_count[%0d] got=%0d want=%0d", i, count, exp_c[i]); end
            checks++; if (tc !== (i % 3 == 0 && i != 0)) begin errors++; $display("FAIL reload_tc[%0d] got=%b want=%b", i, tc, (i % 3 == 0 && i != 0)); end
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL reload_pulses got=%0d want=3", pulses); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reload_busy got=%b want=1", busy); end
        stop = 1'b1; en = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || count !== 8'd3) begin errors++; $display("FAIL reload_stop got=busy%b/%0d want=busy0/3", busy, count); end
        idle_inputs();
    endtask

    task automatic test_en_gating();
        int en_seq [4] = '{1, 0, 1, 0};
        int exp_c  [4] = '{3, 3, 2, 2};
        load_valid = 1'b1; load_value = 8'd4;
        tick();
        load_valid = 1'b0;
        checks++; if (count !== 8'd4) begin errors++; $display("FAIL gate_load got=%0d want=4", count); end
        for (int i = 0; i < 4; i++) begin
            en = en_seq[i][0];
            tick();
            checks++; if (count !== WIDTH'(exp_c[i])) begin errors++; $display("FAIL gate_count[%0d] got=%0d want=%0d", i, count, exp_c[i]); end
        end
        load_valid = 1'b1; load_value = 8'd9; en = 1'b0;
        tick();
        load_valid = 1'b0;
        checks++; if (count !== 8'd2 || busy !== 1'b1) begin errors++; $display("FAIL gate_ignore_load got=%0d/busy%b want=2/busy1", count, busy); end
        en = 1'b1; auto_reload = 1'b1;
        tick();
        tick();
        checks++; if (count !== 8'd4 || tc !== 1'b1) begin errors++; $display("FAIL gate_reload_kept got=%0d/tc%b want=4/tc1", count, tc); end
        stop = 1'b1; en = 1'b0;
        tick();
        idle_inputs();
    endtask

    task automatic test_stop();
        load_valid = 1'b1; load_value = 8'd6;
        tick();
        load_valid = 1'b0; en = 1'b1;
        repeat (4) tick();
        checks++; if (count !== 8'd2) begin errors++; $display("FAIL stop_pre got=%0d want=2", count); end
        stop = 1'b1;
        tick();
        stop = 1'b0; en = 1'b0;
        checks++; if (count !== 8'd2) begin errors++; $display("FAIL stop_count got=%0d want=2", count); end
        checks++; if (busy !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL stop_state got=busy%b/tc%b want=busy0/tc0", busy, tc); end
        load_valid = 1'b1; load_value = 8'd1;
        tick();
        load_valid = 1'b0; en = 1'b1;
        checks++; if (count !== 8'd1 || busy !== 1'b1) begin errors++; $display("FAIL stop_load1 got=%0d/busy%b want=1/busy1", count, busy); end
        tick();
        checks++; if (count !== 8'd0 || tc !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stop_one_run got=%0d/tc%b/busy%b want=0/tc1/busy0", count, tc, busy); end
        idle_inputs();
        tick();
    endtask

    task automatic test_boundaries();
        int early_tc = 0;
        load_valid = 1'b1; load_value = 8'd0;
        tick();
        load_valid = 1'b0;
        checks++; if (count !== 8'd0 || busy !== 1'b0 || tc !== 1'b1) begin errors++; $display("FAIL zero_load got=%0d/busy%b/tc%b want=0/busy0/tc1", count, busy, tc); end
        tick();
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL zero_tc_width got=%b want=0", tc); end
        load_valid = 1'b1; load_value = 8'd255;
        tick();
        load_valid = 1'b0; en = 1'b1;
        checks++; if (count !== 8'd255) begin errors++; $display("FAIL full_load got=%0d want=255", count); end
        for (int i = 1; i < 255; i++) begin
            tick();
            if (tc === 1'b1) early_tc++;
            checks++; if (count !== WIDTH'(255 - i)) begin errors++; $display("FAIL full_count[%0d] got=%0d want=%0d", i, count, 255 - i); end
        end
        checks++; if (early_tc != 0) begin errors++; $display("FAIL full_early_tc got=%0d want=0", early_tc); end
        tick();
        checks++; if (count !== 8'd0 || tc !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_end got=%0d/tc%b/busy%b want=0/tc1/busy0", count, tc, busy); end
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        load_valid = 1'b1; load_value = 8'd10;
        tick();
        load_valid = 1'b0; en = 1'b1;
        repeat (3) tick();
        checks++; if (count !== 8'd7) begin errors++; $display("FAIL areset_pre got=%0d want=7", count); end
        #1 reset = 1'b0;
        model_clear();
        #1;
        checks++; if (count !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL areset_now got=%0d/busy%b/tc%b want=0/busy0/tc0", count, busy, tc); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%b want=1", load_ready); end
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        load_valid = 1'b1; load_value = 8'd2; en = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        checks++; if (count !== 8'd0 || tc !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL areset_resume got=%0d/tc%b/busy%b want=0/tc1/busy0", count, tc, busy); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            load_valid  = ($urandom_range(0, 3) == 0);
            load_value  = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 5));
            en          = ($urandom_range(0, 3) != 0);
            stop        = ($urandom_range(0, 15) == 0);
            auto_reload = ($urandom_range(0, 1) == 1);
            tick();
            checks++; if (count !== WIDTH'(m_value)) begin errors++; $display("FAIL rand_count[%0d] got=%0d want=%0d", i, count, m_value); end
            checks++; if (busy !== m_running) begin errors++; $display("FAIL rand_busy[%0d] got=%b want=%b", i, busy, m_running); end
            checks++; if (tc !== m_pulse) begin errors++; $display("FAIL rand_tc[%0d] got=%b want=%b", i, tc, m_pulse); end
            checks++; if (load_ready !== !m_running) begin errors++; $display("FAIL rand_ready[%0d] got=%b want=%b", i, load_ready, !m_running); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_en_gating();
        test_stop();
        test_boundaries();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have port load_valid, input, 1 bit: a new start value is offered.
REQ-005 The block SHALL have port load_value, input, WIDTH bits: the start value, sampled on load handshake.
REQ-006 The block SHALL have port load_ready, output, 1 bit: the block accepts a load this cycle.
REQ-007 The block SHALL have port en, input, 1 bit: decrement enable.
REQ-008 The block SHALL have port stop, input, 1 bit: abort the current run.
REQ-009 The block SHALL have port auto_reload, input, 1 bit: restart from the stored value at terminal count.
REQ-010 The block SHALL have port count, output, WIDTH bits: the current counter value, driven directly from a register.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-012 The block SHALL have port tc, output, 1 bit: registered terminal-count pulse.

Function
REQ-013 The block SHALL implement two states, IDLE and RUN; busy = (state==RUN); load_ready = (state==IDLE), combinational.
REQ-014 Load handshake SHALL occur on a rising edge with load_valid=1 and load_ready=1; count and internal reload register both take load_value.
REQ-015 A handshake with load_value!=0 SHALL move IDLE->RUN; with load_value==0 the block SHALL stay in IDLE, set count=0, and pulse tc for one cycle.
REQ-016 load_valid during RUN SHALL be ignored, with no change to count or the reload register.
REQ-017 In RUN, when stop=1, the block SHALL go to IDLE with count held and no tc; stop SHALL have priority over en and terminal count.
REQ-018 In RUN with stop=0, en=1, and count>1, the block SHALL set count<=count-1.
REQ-019 In RUN with stop=0, en=1, and count==1 (terminal edge), the block SHALL set tc<=1 for exactly one cycle.
REQ-020 At the terminal edge, if auto_reload=1 (sampled at that edge), count SHALL take the reload value and the block SHALL stay in RUN.
REQ-021 At the terminal edge, if auto_reload=0, count SHALL become 0 and the block SHALL move to IDLE.
REQ-022 In RUN with en=0 and stop=0, count and state SHALL hold.
REQ-023 tc SHALL be 0 on every edge not covered by REQ-015/REQ-019.
REQ-024 In auto-reload, tc SHALL recur every N en-qualified cycles, where N is the reload value.
REQ-025 count SHALL never wrap below 0 or above 2^WIDTH-1; no decrement SHALL occur in IDLE.
REQ-026 A load in IDLE and stop SHALL not interact, because stop is ignored in IDLE.
REQ-027 For load_value = 2^WIDTH-1, the block SHALL count the full range without overflow.

Reset
REQ-028 While reset=0, state SHALL be IDLE, count=0, reload register=0, tc=0, and busy=0; load_ready SHALL be 1.
REQ-029 Reset assertion mid-RUN SHALL clear the block immediately (asynchronously), without waiting for a clock edge and without a tc pulse.
REQ-030 After reset is released, the first load SHALL be accepted on the first rising edge with load_valid=1.

Verification
REQ-031 The bench SHALL cover this scenario: load 5, en=1 continuously, auto_reload=0 -> count 5,4,3,2,1,0; tc high only in the cycle count shows 0; busy falls with tc; load_ready returns to 1.
REQ-032 The bench SHALL cover this scenario: load 3, auto_reload=1, en=1 for 10 cycles -> count sequence 3,2,1,3,2,1,3,2,1,3; tc pulses after each 1->3 transition (3 pulses).
REQ-033 The bench SHALL cover this scenario: load 4, en toggling 1,0,1,0 -> count decrements only on en=1 cycles; load_valid with value 9 during RUN -> ignored, count unaffected.
REQ-034 The bench SHALL cover this scenario: load 6, stop asserted when count=2 together with en=1 -> IDLE, count stays 2, no tc; next load 1 -> single cycle to 0, one tc.
REQ-035 The bench SHALL cover this scenario: load 0 -> stays IDLE, count 0, one-cycle tc; load 255 -> 255 en cycles to tc, no wrap.
REQ-036 The bench SHALL cover this scenario: reset driven low asynchronously mid-RUN at count=7 -> count 0, busy 0, tc 0 before the next clock edge; operation resumes normally after release.
